// File: rtl/stream_demux_2way_pkg.sv
// Shared types for the 2-way stream demultiplexer: per-output buffer occupancy states.
package stream_demux_2way_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/stream_demux_2way_skid_buffer_2entry.sv
// Two-entry FIFO buffer: a push into an empty buffer is visible at the head one cycle later.
// Backpressure is signalled with full; pushes while full are ignored, pops while empty are ignored.
module skid_buffer_2entry
  import stream_demux_2way_pkg::*;
#(
  parameter int bitwidth = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [bitwidth-1:0] data_in,
  input  logic                pop,
  output logic [bitwidth-1:0] head_data,
  output logic                valid,
  output logic                full
);

  buf_state_e          state_q, state_d;
  logic [bitwidth-1:0] head_q, head_d;
  logic [bitwidth-1:0] tail_q, tail_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // head_q is left untouched on the last pop so out_data holds its final value when empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          state_d = BUF_ONE;
          head_d  = data_in;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = data_in;
        end else if (push) begin
          state_d = BUF_FULL;
          tail_d  = data_in;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          state_d = BUF_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign head_data = head_q;
  assign valid     = (state_q != BUF_EMPTY);
  assign full      = (state_q == BUF_FULL);

endmodule

// File: rtl/stream_demux_2way.sv
// 1:2 valid/ready demux into per-output 2-entry buffers; push-to-output latency 1 cycle.
// in_ready depends only on in_sel and the selected buffer's fullness, never on out_*_ready.
module stream_demux_2way
  import stream_demux_2way_pkg::*;
#(
  parameter int bitwidth = 32,
  parameter int cntwidth = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [bitwidth-1:0] in_data,
  input  logic                in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [bitwidth-1:0] out_a_data,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [bitwidth-1:0] out_b_data,
  output logic                out_b_valid,
  input  logic                out_b_ready,
  input  logic                cnt_clr,
  output logic [cntwidth-1:0] cnt_a,
  output logic [cntwidth-1:0] cnt_b
);

  logic                full_a, full_b;
  logic                push_a, push_b;
  logic                pop_a, pop_b;
  logic [cntwidth-1:0] cnt_a_q, cnt_a_d;
  logic [cntwidth-1:0] cnt_b_q, cnt_b_d;

  assign in_ready = in_sel ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && !in_sel;
  assign push_b   = in_valid && in_ready && in_sel;
  assign pop_a    = out_a_valid && out_a_ready;
  assign pop_b    = out_b_valid && out_b_ready;

  skid_buffer_2entry #(.bitwidth(bitwidth)) u_buf_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_a),
    .data_in   (in_data),
    .pop       (pop_a),
    .head_data (out_a_data),
    .valid     (out_a_valid),
    .full      (full_a)
  );

  skid_buffer_2entry #(.bitwidth(bitwidth)) u_buf_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_b),
    .data_in   (in_data),
    .pop       (pop_b),
    .head_data (out_b_data),
    .valid     (out_b_valid),
    .full      (full_b)
  );

  // A clear in the same cycle as a pop still records that pop.
  always_comb begin
    cnt_a_d = cnt_clr ? {{(cntwidth-1){1'b0}}, pop_a}
                      : cnt_a_q + {{(cntwidth-1){1'b0}}, pop_a};
    cnt_b_d = cnt_clr ? {{(cntwidth-1){1'b0}}, pop_b}
                      : cnt_b_q + {{(cntwidth-1){1'b0}}, pop_b};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule

// File: tb/tb_stream_demux_2way.sv
// Bench for stream_demux_2way: directed steps plus random traffic against a queue-based model.
module tb_stream_demux_2way;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a_data;
  logic        out_a_valid;
  logic        out_a_ready;
  logic [31:0] out_b_data;
  logic        out_b_valid;
  logic        out_b_ready;
  logic        cnt_clr;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  int checks   = 0;
  int failures = 0;
  bit do_chk   = 0;

  // Reference model: each output is a FIFO of at most two words.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] last_a = 0, last_b = 0;
  int          ca = 0, cb = 0;

  stream_demux_2way #(.bitwidth(32), .cntwidth(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_clr     (cnt_clr),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, then advance one clock and update the model.
  task automatic step();
    bit push, popa, popb;
    int sz;
    #1;
    if (do_chk) begin
      chk("a_valid", {31'd0, out_a_valid}, {31'd0, qa.size() != 0});
      chk("b_valid", {31'd0, out_b_valid}, {31'd0, qb.size() != 0});
      chk("a_data", out_a_data, (qa.size() != 0) ? qa[0] : last_a);
      chk("b_data", out_b_data, (qb.size() != 0) ? qb[0] : last_b);
      chk("cnt_a", {16'd0, cnt_a}, ca);
      chk("cnt_b", {16'd0, cnt_b}, cb);
      sz = in_sel ? qb.size() : qa.size();
      chk("in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
    end
    sz   = in_sel ? qb.size() : qa.size();
    push = in_valid && (sz < 2);
    popa = out_a_ready && (qa.size() != 0);
    popb = out_b_ready && (qb.size() != 0);
    @(posedge clk);
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      last_a = 0;
      last_b = 0;
      ca = 0;
      cb = 0;
    end else begin
      if (popa) last_a = qa.pop_front();
      if (popb) last_b = qb.pop_front();
      if (push) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
      if (qa.size() != 0) last_a = qa[0];
      if (qb.size() != 0) last_b = qb[0];
      ca = cnt_clr ? int'(popa) : (ca + int'(popa)) % 65536;
      cb = cnt_clr ? int'(popb) : (cb + int'(popb)) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid    = 0;
    in_sel      = 0;
    in_data     = 0;
    out_a_ready = 0;
    out_b_ready = 0;
    cnt_clr     = 0;
  endtask

  initial begin
    int n;
    reset_n = 0;
    idle();
    @(negedge clk);

    // 1. reset held two cycles
    step();
    do_chk = 1;
    step();
    reset_n = 1;
    chk("rst_a_valid", {31'd0, out_a_valid}, 0);
    chk("rst_b_valid", {31'd0, out_b_valid}, 0);
    chk("rst_a_data", out_a_data, 0);
    chk("rst_cnt_b", {16'd0, cnt_b}, 0);
    in_sel = 0; step();
    in_sel = 1; step();

    // 2. single word to A with consumer ready
    in_valid = 1; in_sel = 0; in_data = 32'hDEADBEEF; out_a_ready = 1;
    step();
    in_valid = 0;
    chk("t2_a_valid", {31'd0, out_a_valid}, 1);
    chk("t2_a_data", out_a_data, 32'hDEADBEEF);
    chk("t2_b_valid", {31'd0, out_b_valid}, 0);
    step();
    chk("t2_cnt_a", {16'd0, cnt_a}, 1);

    // 3. fill B while stalled, then release
    idle();
    in_valid = 1; in_sel = 1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    in_valid = 0;
    in_sel = 1; #1 chk("t3_rdy_b", {31'd0, in_ready}, 0);
    in_sel = 0; #1 chk("t3_rdy_a", {31'd0, in_ready}, 1);
    in_sel = 1; step();
    out_b_ready = 1;
    chk("t3_first", out_b_data, 32'h11);
    step();
    chk("t3_second", out_b_data, 32'h22);
    step();
    chk("t3_cnt_b", {16'd0, cnt_b}, 2);
    chk("t3_b_empty", {31'd0, out_b_valid}, 0);

    // 4. B full and stalled while A streams
    idle();
    in_valid = 1; in_sel = 1; in_data = 32'h44; step();
    in_data = 32'h55; step();
    in_sel = 0; in_data = 32'h33; out_a_ready = 1;
    for (int i = 0; i < 5; i++) step();
    chk("t4_b_data", out_b_data, 32'h44);
    chk("t4_a_data", out_a_data, 32'h33);

    // random traffic
    idle();
    for (int i = 0; i < 400; i++) begin
      in_valid    = $urandom_range(0, 1);
      in_sel      = $urandom_range(0, 1);
      in_data     = $urandom;
      out_a_ready = ($urandom_range(0, 3) != 0);
      out_b_ready = ($urandom_range(0, 2) == 0);
      cnt_clr     = ($urandom_range(0, 31) == 0);
      step();
    end

    // 5. counter wrap and clear-with-pop
    idle();
    out_b_ready = 1;
    step(); step();
    cnt_clr = 1; out_b_ready = 0; step();
    cnt_clr = 0;
    in_valid = 1; in_sel = 0; out_a_ready = 1;
    n = 0;
    while (ca != 65535 && n < 70000) begin
      in_data = n;
      step();
      n++;
    end
    chk("t5_ffff", {16'd0, cnt_a}, 32'h0000FFFF);
    in_valid = 0; step();
    chk("t5_wrap", {16'd0, cnt_a}, 0);
    in_valid = 1; out_a_ready = 0; in_data = 32'hA5A5; step();
    in_valid = 0; out_a_ready = 1; cnt_clr = 1; step();
    cnt_clr = 0;
    chk("t5_clr_pop", {16'd0, cnt_a}, 1);

    // 6. reset with both buffers full
    idle();
    in_valid = 1;
    in_sel = 0; in_data = 32'hA1; step();
    in_data = 32'hA2; step();
    in_sel = 1; in_data = 32'hB1; step();
    in_data = 32'hB2; step();
    in_valid = 0;
    chk("t6_full_a", {31'd0, out_a_valid}, 1);
    reset_n = 0; step();
    reset_n = 1;
    chk("t6_a_valid", {31'd0, out_a_valid}, 0);
    chk("t6_b_valid", {31'd0, out_b_valid}, 0);
    out_a_ready = 1; out_b_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("t6_a_quiet", {31'd0, out_a_valid}, 0);
    chk("t6_b_data", out_b_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
